// File: rtl/head_ptr_lookup.sv
// head_ptr_lookup: reads each hashed command's bucket head pointer from an
// internal head-pointer RAM and passes command + head pointer downstream.
// Owns the head-pointer RAM: clears it after reset, applies head-table writes
// from the data-table engines and forwards them into in-flight/buffered lookups.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   task_*_i / task_ready_o     : hashed command input (valid/ready)
//   pdata_*_o / pdata_ready_i   : command + head pointer output (valid/ready)
//   ht_wr_*_i                   : head-table write port
//   clear_busy_o                : post-reset table clear in progress
module head_ptr_lookup #(
  parameter int unsigned KEY_WIDTH      = 32,
  parameter int unsigned VALUE_WIDTH    = 16,
  parameter int unsigned BUCKET_WIDTH   = 8,
  parameter int unsigned HEAD_PTR_WIDTH = 10,
  parameter int unsigned OUT_FIFO_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                task_opcode_i,
  input  logic [KEY_WIDTH-1:0]      task_key_i,
  input  logic [VALUE_WIDTH-1:0]    task_value_i,
  input  logic [BUCKET_WIDTH-1:0]   task_bucket_i,
  input  logic                      task_valid_i,
  output logic                      task_ready_o,
  output logic [1:0]                pdata_opcode_o,
  output logic [KEY_WIDTH-1:0]      pdata_key_o,
  output logic [VALUE_WIDTH-1:0]    pdata_value_o,
  output logic [BUCKET_WIDTH-1:0]   pdata_bucket_o,
  output logic [HEAD_PTR_WIDTH-1:0] pdata_head_ptr_o,
  output logic                      pdata_head_ptr_val_o,
  output logic                      pdata_valid_o,
  input  logic                      pdata_ready_i,
  input  logic [BUCKET_WIDTH-1:0]   ht_wr_addr_i,
  input  logic [HEAD_PTR_WIDTH-1:0] ht_wr_data_ptr_i,
  input  logic                      ht_wr_data_ptr_val_i,
  input  logic                      ht_wr_en_i,
  output logic                      clear_busy_o
);

  localparam int unsigned TABLE_DEPTH = 1 << BUCKET_WIDTH;
  localparam int unsigned CLR_W       = BUCKET_WIDTH + 1;
  localparam int unsigned CNT_W       = $clog2(OUT_FIFO_DEPTH) + 1;
  localparam int unsigned FIFO_AW     = $clog2(OUT_FIFO_DEPTH);

  typedef struct packed {
    logic [1:0]              opcode;
    logic [KEY_WIDTH-1:0]    key;
    logic [VALUE_WIDTH-1:0]  value;
    logic [BUCKET_WIDTH-1:0] bucket;
  } cmd_t;

  typedef struct packed {
    logic                      ptr_val;
    logic [HEAD_PTR_WIDTH-1:0] ptr;
  } head_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // FSM / clear counter
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CLR_W-1:0] r_clr_cnt;
  logic [CLR_W-1:0] w_clr_cnt_nxt;
  logic             r_clear_busy;
  logic             r_task_ready;

  // RAM ports
  head_t                   r_mem [TABLE_DEPTH];
  logic                    w_ram_we;
  logic [BUCKET_WIDTH-1:0] w_ram_addr;
  head_t                   w_ram_wdata;
  logic [BUCKET_WIDTH-1:0] r_rd_addr;
  head_t                   r_rd_data;

  // Lookup pipeline
  logic  r_s1_vld, r_s2_vld;
  cmd_t  r_s1_cmd, r_s2_cmd;
  logic  r_s1_ovr_vld, r_s2_ovr_vld;
  head_t r_s1_ovr, r_s2_ovr;
  head_t w_s2_head;

  // Output FIFO
  cmd_t               r_fifo_cmd  [OUT_FIFO_DEPTH];
  head_t              r_fifo_head [OUT_FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_fifo_cnt;
  logic [CNT_W-1:0]   w_fifo_cnt_nxt;
  logic               r_pdata_valid;

  logic             w_accept;
  logic             w_pop;
  logic             w_ht_wr;
  head_t            w_wr_head;
  cmd_t             w_task_cmd;
  logic [CNT_W-1:0] w_occ;
  logic [CNT_W-1:0] w_occ_nxt;

  assign w_accept   = task_valid_i && r_task_ready;
  assign w_pop      = r_pdata_valid && pdata_ready_i;
  // Engine writes only take effect once the table clear has finished
  assign w_ht_wr    = ht_wr_en_i && (r_state == ST_RUN);
  assign w_wr_head  = '{ptr_val: ht_wr_data_ptr_val_i, ptr: ht_wr_data_ptr_i};
  assign w_task_cmd = '{opcode: task_opcode_i, key: task_key_i,
                        value: task_value_i, bucket: task_bucket_i};

  // Everything accepted and not yet popped: S1, S2 and FIFO entries
  assign w_occ          = r_fifo_cnt + CNT_W'(r_s1_vld) + CNT_W'(r_s2_vld);
  assign w_occ_nxt      = w_occ + CNT_W'(w_accept) - CNT_W'(w_pop);
  assign w_fifo_cnt_nxt = r_fifo_cnt + CNT_W'(r_s2_vld) - CNT_W'(w_pop);

  // Clear FSM next state and RAM write-port steering
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_ram_we      = 1'b0;
    w_ram_addr    = ht_wr_addr_i;
    w_ram_wdata   = w_wr_head;
    case (r_state)
      ST_CLEAR: begin
        w_ram_we      = 1'b1;
        w_ram_addr    = r_clr_cnt[BUCKET_WIDTH-1:0];
        w_ram_wdata   = '0;
        w_clr_cnt_nxt = r_clr_cnt + CLR_W'(1);
        // Counter MSB sets right after the last address has been written
        if (w_clr_cnt_nxt[BUCKET_WIDTH]) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_ram_we = w_ht_wr;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // FSM state, clear counter and handshake-side flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_CLEAR;
      r_clr_cnt    <= '0;
      r_clear_busy <= 1'b1;
      r_task_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_clear_busy <= (w_state_nxt == ST_CLEAR);
      r_task_ready <= (w_state_nxt == ST_RUN) && (w_occ_nxt < CNT_W'(OUT_FIFO_DEPTH));
    end
  end

  // Simple dual-port RAM, two-cycle read (address reg + data reg), old data on collision
  always_ff @(posedge clk_i) begin
    if (w_ram_we) begin
      r_mem[w_ram_addr] <= w_ram_wdata;
    end
    r_rd_addr <= task_bucket_i;
    r_rd_data <= r_mem[r_rd_addr];
  end

  // S2 result: a write this cycle beats a captured override, which beats RAM data
  always_comb begin
    w_s2_head = r_s2_ovr_vld ? r_s2_ovr : r_rd_data;
    if (w_ht_wr && (ht_wr_addr_i == r_s2_cmd.bucket)) begin
      w_s2_head = w_wr_head;
    end
  end

  // S1/S2 command stages with write-override capture
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_s1_vld     <= 1'b0;
      r_s1_cmd     <= '0;
      r_s1_ovr_vld <= 1'b0;
      r_s1_ovr     <= '0;
      r_s2_vld     <= 1'b0;
      r_s2_cmd     <= '0;
      r_s2_ovr_vld <= 1'b0;
      r_s2_ovr     <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_cmd     <= w_task_cmd;
        r_s1_ovr_vld <= w_ht_wr && (ht_wr_addr_i == task_bucket_i);
        r_s1_ovr     <= w_wr_head;
      end
      r_s2_vld <= r_s1_vld;
      r_s2_cmd <= r_s1_cmd;
      if (w_ht_wr && (ht_wr_addr_i == r_s1_cmd.bucket)) begin
        r_s2_ovr_vld <= 1'b1;
        r_s2_ovr     <= w_wr_head;
      end else begin
        r_s2_ovr_vld <= r_s1_ovr_vld;
        r_s2_ovr     <= r_s1_ovr;
      end
    end
  end

  // Output FIFO; buffered entries are patched by matching head-table writes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < OUT_FIFO_DEPTH; i++) begin
        r_fifo_cmd[FIFO_AW'(i)]  <= '0;
        r_fifo_head[FIFO_AW'(i)] <= '0;
      end
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_fifo_cnt    <= '0;
      r_pdata_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < OUT_FIFO_DEPTH; i++) begin
        if (w_ht_wr && (r_fifo_cmd[FIFO_AW'(i)].bucket == ht_wr_addr_i)) begin
          r_fifo_head[FIFO_AW'(i)] <= w_wr_head;
        end
      end
      // Push after the patch loop so a freshly pushed entry wins its slot
      if (r_s2_vld) begin
        r_fifo_cmd[r_wr_ptr]  <= r_s2_cmd;
        r_fifo_head[r_wr_ptr] <= w_s2_head;
        r_wr_ptr              <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      r_fifo_cnt    <= w_fifo_cnt_nxt;
      r_pdata_valid <= (w_fifo_cnt_nxt != '0);
    end
  end

  assign task_ready_o         = r_task_ready;
  assign clear_busy_o         = r_clear_busy;
  assign pdata_valid_o        = r_pdata_valid;
  assign pdata_opcode_o       = r_fifo_cmd[r_rd_ptr].opcode;
  assign pdata_key_o          = r_fifo_cmd[r_rd_ptr].key;
  assign pdata_value_o        = r_fifo_cmd[r_rd_ptr].value;
  assign pdata_bucket_o       = r_fifo_cmd[r_rd_ptr].bucket;
  assign pdata_head_ptr_o     = r_fifo_head[r_rd_ptr].ptr;
  assign pdata_head_ptr_val_o = r_fifo_head[r_rd_ptr].ptr_val;

  // Engine writes are not expected while the table is being cleared
  ap_no_wr_during_clear: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(ht_wr_en_i && (r_state == ST_CLEAR)))
    else $error("ht_wr_en_i asserted during head-table clear");

endmodule
